// File: rtl/pmod_ad1_pkg.sv
// Shared types and constants for the PmodAD1 dual-channel ADC reader.
package pmod_ad1_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_ZEROS = 4;

  // A well-formed AD7476A frame starts with LEAD_ZEROS zero bits.
  function automatic logic lead_zero_err(input logic [FRAME_BITS-1:0] frame);
    return |frame[FRAME_BITS-1 -: LEAD_ZEROS];
  endfunction

endpackage

// File: rtl/pmod_ad1_reader_if.sv
// Pin and sample bundle between the PmodAD1 reader, the ADC pins and the fabric.
interface pmod_ad1_reader_if;
  import pmod_ad1_pkg::*;

  logic                 START;
  logic                 SDATA0;
  logic                 SDATA1;
  logic                 SCLK;
  logic                 CSn;
  logic [DATA_BITS-1:0] DATA0;
  logic [DATA_BITS-1:0] DATA1;
  logic                 VALID;
  logic                 BUSY;
  logic                 FRAME_ERR;

  modport master (
    input  START, SDATA0, SDATA1,
    output SCLK, CSn, DATA0, DATA1, VALID, BUSY, FRAME_ERR
  );

  modport slave (
    output START, SDATA0, SDATA1,
    input  SCLK, CSn, DATA0, DATA1, VALID, BUSY, FRAME_ERR
  );

endinterface

// File: rtl/adc_shift_in.sv
// MSB-first serial-to-parallel shift register for one ADC data line.
module adc_shift_in
  import pmod_ad1_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  sdata,
  output logic [FRAME_BITS-1:0] sr
);

  logic [FRAME_BITS-1:0] sr_r;

  // Shift one bit in from the LSB end on every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= {FRAME_BITS{1'b0}};
    end else if (shift_en) begin
      sr_r <= {sr_r[FRAME_BITS-2:0], sdata};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign sr = sr_r;

endmodule

// File: rtl/pmod_ad1_reader.sv
// PmodAD1 reader: runs one 16-bit SPI-style frame per START and captures both
// channels into 12-bit samples with a one-cycle VALID strobe.
module pmod_ad1_reader #(
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 5
) (
  input  logic               Clk,
  input  logic               Rst_n,
  pmod_ad1_reader_if.master  bus
);
  import pmod_ad1_pkg::*;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [QW-1:0] QUIET_LAST = (QUIET_CYCLES > 0) ? QW'(QUIET_CYCLES - 1) : {QW{1'b0}};
  localparam logic          NO_QUIET   = (QUIET_CYCLES == 0);

  state_e               state_r,     state_s;
  logic [DW-1:0]        div_cnt_r,   div_cnt_s;
  logic                 phase_r,     phase_s;
  logic [BW-1:0]        bit_cnt_r,   bit_cnt_s;
  logic [QW-1:0]        quiet_cnt_r, quiet_cnt_s;
  logic                 sclk_r,      sclk_s;
  logic                 csn_r,       csn_s;
  logic                 valid_r,     valid_s;
  logic                 busy_r,      busy_s;
  logic                 frame_err_r, frame_err_s;
  logic [DATA_BITS-1:0] data0_r,     data0_s;
  logic [DATA_BITS-1:0] data1_r,     data1_s;

  logic                  shift_en_s;
  logic                  release_s;
  logic                  release_nx_s;
  logic [FRAME_BITS-1:0] sr0_s;
  logic [FRAME_BITS-1:0] sr1_s;

  adc_shift_in u_sr0 (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .shift_en (shift_en_s),
    .sdata    (bus.SDATA0),
    .sr       (sr0_s)
  );

  adc_shift_in u_sr1 (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .shift_en (shift_en_s),
    .sdata    (bus.SDATA1),
    .sr       (sr1_s)
  );

  // The final CSn-high cycle after a frame behaves like IDLE, so that a held
  // START yields exactly 1+QUIET_CYCLES high cycles between frames.
  assign release_s = (state_r == DONE && NO_QUIET) ||
                     (state_r == QUIET && quiet_cnt_r == QUIET_LAST);

  // Next-state, divider/bit counters and next values of every registered output.
  always_comb begin
    state_s     = state_r;
    div_cnt_s   = div_cnt_r;
    phase_s     = phase_r;
    bit_cnt_s   = bit_cnt_r;
    quiet_cnt_s = quiet_cnt_r;
    sclk_s      = sclk_r;
    csn_s       = csn_r;
    valid_s     = 1'b0;
    shift_en_s  = 1'b0;
    data0_s     = data0_r;
    data1_s     = data1_r;
    frame_err_s = frame_err_r;

    case (state_r)
      IDLE: begin
        sclk_s = 1'b1;
        if (bus.START) begin
          state_s   = SETUP;
          div_cnt_s = {DW{1'b0}};
          csn_s     = 1'b0;
        end else begin
          csn_s = 1'b1;
        end
      end

      SETUP: begin
        if (div_cnt_r == DIV_LAST) begin
          state_s   = SHIFT;
          div_cnt_s = {DW{1'b0}};
          phase_s   = 1'b0;
          bit_cnt_s = {BW{1'b0}};
          sclk_s    = 1'b0;
        end else begin
          div_cnt_s = div_cnt_r + 1'b1;
        end
      end

      SHIFT: begin
        if (div_cnt_r != DIV_LAST) begin
          div_cnt_s = div_cnt_r + 1'b1;
        end else if (!phase_r) begin
          // This edge raises SCLK: the ADC data has been stable for CLK_DIV cycles.
          div_cnt_s  = {DW{1'b0}};
          phase_s    = 1'b1;
          sclk_s     = 1'b1;
          shift_en_s = 1'b1;
        end else if (bit_cnt_r == BIT_LAST) begin
          div_cnt_s   = {DW{1'b0}};
          state_s     = DONE;
          csn_s       = 1'b1;
          sclk_s      = 1'b1;
          valid_s     = 1'b1;
          data0_s     = sr0_s[DATA_BITS-1:0];
          data1_s     = sr1_s[DATA_BITS-1:0];
          frame_err_s = lead_zero_err(sr0_s) | lead_zero_err(sr1_s);
        end else begin
          div_cnt_s = {DW{1'b0}};
          bit_cnt_s = bit_cnt_r + 1'b1;
          phase_s   = 1'b0;
          sclk_s    = 1'b0;
        end
      end

      DONE, QUIET: begin
        sclk_s = 1'b1;
        if (release_s) begin
          if (bus.START) begin
            state_s   = SETUP;
            div_cnt_s = {DW{1'b0}};
            csn_s     = 1'b0;
          end else begin
            state_s = IDLE;
            csn_s   = 1'b1;
          end
        end else if (state_r == DONE) begin
          state_s     = QUIET;
          quiet_cnt_s = {QW{1'b0}};
          csn_s       = 1'b1;
        end else begin
          quiet_cnt_s = quiet_cnt_r + 1'b1;
          csn_s       = 1'b1;
        end
      end

      default: begin
        state_s = IDLE;
        csn_s   = 1'b1;
        sclk_s  = 1'b1;
      end
    endcase

    release_nx_s = (state_s == DONE && NO_QUIET) ||
                   (state_s == QUIET && quiet_cnt_s == QUIET_LAST);
    busy_s       = !(state_s == IDLE || release_nx_s);
  end

  // State, counters and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= IDLE;
      div_cnt_r   <= {DW{1'b0}};
      phase_r     <= 1'b0;
      bit_cnt_r   <= {BW{1'b0}};
      quiet_cnt_r <= {QW{1'b0}};
      sclk_r      <= 1'b1;
      csn_r       <= 1'b1;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      data0_r     <= {DATA_BITS{1'b0}};
      data1_r     <= {DATA_BITS{1'b0}};
    end else begin
      state_r     <= state_s;
      div_cnt_r   <= div_cnt_s;
      phase_r     <= phase_s;
      bit_cnt_r   <= bit_cnt_s;
      quiet_cnt_r <= quiet_cnt_s;
      sclk_r      <= sclk_s;
      csn_r       <= csn_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      frame_err_r <= frame_err_s;
      data0_r     <= data0_s;
      data1_r     <= data1_s;
    end
  end

  assign bus.SCLK      = sclk_r;
  assign bus.CSn       = csn_r;
  assign bus.VALID     = valid_r;
  assign bus.BUSY      = busy_r;
  assign bus.FRAME_ERR = frame_err_r;
  assign bus.DATA0     = data0_r;
  assign bus.DATA1     = data1_r;

endmodule

// File: doc/pmod_ad1_reader.md
Name: pmod_ad1_reader

Overview:
- Master-side reader for the dual-channel PmodAD1 ADC (two AD7476A-class converters sharing SCLK and CSn).
- On a START request it runs one 16-bit serial frame and captures both channels' SDATA lines into 12-bit samples. It presents the samples with a one-cycle VALID strobe.
- It is the capture counterpart of the DAC serializer path. It feeds ADC samples into the fabric, e.g. for loopback against the DAC output.

Parameters:
- CLK_DIV, 2: Clk cycles per SCLK half-period. Must be >= 1. SCLK = Clk/(2*CLK_DIV), i.e. 25 MHz at a 100 MHz Clk.
- QUIET_CYCLES, 5: Clk cycles CSn is held high after a frame before the next START is accepted. 0 is legal.

Ports:
- Clk  input  1  system clock
- Rst_n  input  1  asynchronous active-low reset
- START  input  1  conversion request; sampled only in IDLE
- SDATA0  input  1  serial data, channel 0
- SDATA1  input  1  serial data, channel 1
- SCLK  output  1  serial clock to ADC; idles high
- CSn  output  1  chip select, active low
- DATA0  output  12  last captured channel-0 sample
- DATA1  output  12  last captured channel-1 sample
- VALID  output  1  one-cycle strobe: DATA0/DATA1/FRAME_ERR updated
- BUSY  output  1  frame or quiet period in progress
- FRAME_ERR  output  1  leading-zero check failed on either channel in the last frame

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous, active-low (Rst_n). All outputs are registered.
- Reset values: CSn=1, SCLK=1, VALID=0, BUSY=0, DATA0=0, DATA1=0, FRAME_ERR=0, state=IDLE, counters=0.
- States: IDLE, SETUP, SHIFT, DONE, QUIET.
- IDLE:
  - CSn=1, SCLK=1, BUSY=0.
  - START=1 at edge k → SETUP. From edge k, CSn=0 and BUSY=1.
- SETUP: lasts CLK_DIV cycles with SCLK=1 and CSn=0. Gives the ADC its CSn-to-SCLK setup time.
- SHIFT:
  - 16 bit periods. Each period is CLK_DIV cycles SCLK=0, then CLK_DIV cycles SCLK=1.
  - The ADC changes data on SCLK falling edges.
  - On the Clk edge that drives SCLK 0→1, shift SDATA0/SDATA1 into 16-bit shift registers, MSB first. No other edge samples.
  - Bit counter runs 0..15. The frame has exactly 16 rising SCLK edges while CSn=0.
- DONE:
  - Entered after the 16th high half-period. Lasts exactly 1 cycle.
  - CSn=1, SCLK=1, VALID=1.
  - DATA0/DATA1 load shift-register bits [11:0].
  - FRAME_ERR loads (|sr0[15:12]) | (|sr1[15:12]).
- QUIET:
  - Lasts QUIET_CYCLES cycles with CSn=1, BUSY=1, then → IDLE.
  - If QUIET_CYCLES=0, DONE goes directly to IDLE.
- Latency: VALID is high in the cycle following edge k + CLK_DIV*33. With CLK_DIV=2 that is the cycle starting at edge k+66, i.e. 67 cycles after START is sampled.
- DATA0, DATA1 and FRAME_ERR hold their values until the next DONE. VALID is never high for two consecutive cycles.
- START:
  - START is ignored whenever BUSY=1; no queuing.
  - START held high continuously gives back-to-back frames. CSn stays high for 1+QUIET_CYCLES cycles between frames.
- SDATA handling: SDATA is used without synchronizers. It is stable for CLK_DIV Clk cycles before the sampling edge.
- Reset mid-frame: takes effect immediately without Clk. CSn and SCLK go high and no VALID is issued. The partial frame is discarded and DATA is cleared.

Decomposition:
- Package pmod_ad1_pkg:
  - state enum (IDLE, SETUP, SHIFT, DONE, QUIET)
  - FRAME_BITS=16, DATA_BITS=12, LEAD_ZEROS=4
- Sub-module adc_shift_in: 16-bit MSB-first shift register with a shift-enable input. Instantiated once per channel.
- The FSM, SCLK divider and bit counter stay in pmod_ad1_reader.
- The bench uses a behavioural ADC model, pmod_ad1_model. It drives 4 zeros and then 12 data bits on SCLK falling edges after CSn falls, with an optional fault-injection input.

Test Plan:
- Reset, START=0 for 200 cycles → CSn=1, SCLK=1, BUSY=0, VALID=0 throughout.
- Model ch0=12'hC93, ch1=12'h895, one-cycle START (CLK_DIV=2) → 16 SCLK rising edges while CSn=0. VALID=1 for one cycle, 67 cycles after START. DATA0=12'hC93, DATA1=12'h895, FRAME_ERR=0.
- Extremes: ch0=12'h000, ch1=12'hFFF, then swapped → exact values captured both frames, FRAME_ERR=0.
- Model forces bit 14 of the ch1 frame to 1, ch1 data 12'h589 → VALID with FRAME_ERR=1 and DATA1=12'h589. The next clean frame clears FRAME_ERR to 0.
- START held high for 3 frames, QUIET_CYCLES=5 → 3 VALID strobes. CSn high for exactly 6 cycles between frames. Extra START pulses during BUSY produce no extra frame.
- Rst_n pulsed low after the 8th SCLK rising edge → CSn=1, SCLK=1 immediately, no VALID, DATA=0. A subsequent START with ch0=12'h7A1 returns DATA0=12'h7A1.
